// File: rtl/l2_burst_pkg.sv
// Shared types and default geometry for the L2 burst responder.
// The top derives its own widths from its parameters; these are the defaults.
package l2_burst_pkg;

    localparam int LINE_W      = 256;
    localparam int BEAT_W      = 64;
    localparam int ADDR_W      = 32;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int BEAT_BYTES  = BEAT_W / 8;
    localparam int OFFSET_BITS = $clog2(LINE_W / 8);

    typedef logic [LINE_W-1:0] line_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESPOND  = 2'd3
    } state_e;

endpackage

// File: rtl/l2_beat_buffer.sv
// One line of storage split into beat slots: loaded whole with write data,
// or filled slot-by-slot from returning read beats.
module l2_beat_buffer
    import l2_burst_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_W,
    parameter int BEAT_WIDTH = BEAT_W,
    parameter int NBEATS     = LINE_WIDTH / BEAT_WIDTH,
    parameter int IDX_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_load,
    input  logic [LINE_WIDTH-1:0]                 i_wdata,
    input  logic                                  i_we,
    input  logic [IDX_W-1:0]                      i_idx,
    input  logic [BEAT_WIDTH-1:0]                 i_beat,
    output logic [NBEATS-1:0][BEAT_WIDTH-1:0]     o_slots,
    output logic [NBEATS-1:0][BEAT_WIDTH-1:0]     o_slots_nxt
);

    for (genvar g = 0; g < NBEATS; g++) begin : g_slot
        logic                  w_hit;
        logic [BEAT_WIDTH-1:0] r_slot;

        assign w_hit          = i_we && (i_idx == IDX_W'(g));
        assign o_slots_nxt[g] = i_load ? i_wdata[g*BEAT_WIDTH +: BEAT_WIDTH]
                              : (w_hit ? i_beat : r_slot);
        assign o_slots[g]     = r_slot;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) r_slot <= '0;
            else        r_slot <= o_slots_nxt[g];
        end
    end

endmodule

// File: rtl/l2_burst_responder.sv
// Turns one 256-bit line read/write into a fixed-length 64-bit beat burst on
// physical memory, then signals completion with a single-cycle mem_resp.
module l2_burst_responder
    import l2_burst_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_W,
    parameter int BEAT_WIDTH = BEAT_W,
    parameter int ADDR_WIDTH = ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [LINE_WIDTH-1:0] mem_wdata,
    output logic [LINE_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [BEAT_WIDTH-1:0] pmem_wdata,
    input  logic [BEAT_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam int NBEATS  = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int BEAT_SH = $clog2(BEAT_WIDTH / 8);
    localparam int OFF_W   = $clog2(LINE_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBEATS - 1);

    state_e                           r_state;
    state_e                           w_state_nxt;
    logic [CNT_W-1:0]                 r_cnt;
    logic                             r_abort;
    logic [ADDR_WIDTH-1:0]            r_base;
    logic [LINE_WIDTH-1:0]            r_rdata;

    logic                             w_rd;
    logic                             w_wr;
    logic                             w_burst;
    logic                             w_start;
    logic                             w_beat_done;
    logic                             w_last;
    logic                             w_abort_nxt;
    logic [ADDR_WIDTH-1:0]            w_base_in;
    logic                             w_unused_off;
    logic [NBEATS-1:0][BEAT_WIDTH-1:0] w_slots;
    logic [NBEATS-1:0][BEAT_WIDTH-1:0] w_slots_nxt;

    assign w_rd        = (r_state == RD_BURST);
    assign w_wr        = (r_state == WR_BURST);
    assign w_burst     = w_rd || w_wr;
    assign w_start     = (r_state == IDLE) && (mem_read || mem_write);
    assign w_beat_done = w_burst && pmem_resp;
    assign w_last      = w_beat_done && (r_cnt == LAST);
    // A dropped request only suppresses the response; the burst still runs out.
    assign w_abort_nxt = r_abort || (w_rd && !mem_read) || (w_wr && !mem_write);
    assign w_base_in   = {mem_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
    assign w_unused_off = ^mem_address[OFF_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (mem_write)     w_state_nxt = WR_BURST;
                else if (mem_read) w_state_nxt = RD_BURST;
            end
            RD_BURST, WR_BURST: begin
                if (w_last) w_state_nxt = RESPOND;
            end
            RESPOND: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_base  <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_base  <= w_base_in;
                r_cnt   <= '0;
                r_abort <= 1'b0;
            end else begin
                if (w_beat_done) r_cnt   <= r_cnt + CNT_W'(1);
                if (w_burst)     r_abort <= w_abort_nxt;
            end
            // Take the final beat straight from the buffer's next value so the
            // line is visible in the same cycle as mem_resp.
            if (w_last && w_rd && !w_abort_nxt) r_rdata <= w_slots_nxt;
        end
    end

    l2_beat_buffer #(
        .LINE_WIDTH (LINE_WIDTH),
        .BEAT_WIDTH (BEAT_WIDTH),
        .NBEATS     (NBEATS),
        .IDX_W      (CNT_W)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_start),
        .i_wdata     (mem_wdata),
        .i_we        (w_rd && pmem_resp),
        .i_idx       (r_cnt),
        .i_beat      (pmem_rdata),
        .o_slots     (w_slots),
        .o_slots_nxt (w_slots_nxt)
    );

    assign pmem_read    = w_rd;
    assign pmem_write   = w_wr;
    assign pmem_address = w_burst ? (r_base + (ADDR_WIDTH'(r_cnt) << BEAT_SH)) : '0;
    assign pmem_wdata   = w_wr ? w_slots[r_cnt] : '0;
    assign mem_resp     = (r_state == RESPOND) && !r_abort;
    assign mem_rdata    = r_rdata;

endmodule
